// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- data-memory port between the load/store controller and memory.
//   dmem_req   : request, held until ack or timeout (controller -> memory)
//   dmem_we    : 1 = write
//   dmem_addr  : word-aligned byte address
//   dmem_be    : byte enables
//   dmem_wdata : lane-replicated store data
//   dmem_ack   : acknowledge (memory -> controller)
//   dmem_rdata : read word (memory -> controller)
interface lsu_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller.
// Accepts a LOAD/STORE flagged by the decoder, stalls the pipeline, runs one
// req/ack transaction on the data-memory port and returns the extended load
// result. Illegal funct3, misalignment (when trapped) and bus timeouts end the
// access with an err pulse.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   mem_flag, opcode,
//   funct3, addr, wdata     : access request from execute
//   stall                   : hold the pipeline
//   rdata, rvalid           : load result and its one-cycle valid pulse
//   done, err               : access finished / finished with error
//   dmem                    : data-memory port (lsu_ctrl_if.master)
// Parameter TIMEOUT_CYCLES : REQ cycles without ack before abort (>= 1).
// Macro LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//   error out; otherwise the offset is masked to natural alignment.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_flag,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              done,
  output logic              err,
  lsu_ctrl_if.master        dmem
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_load_q, is_load_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [31:0]        baddr_q, baddr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        bwdata_q, bwdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               is_ld, is_st, access, illegal, misalign;
  logic [1:0]         off_eff;
  logic [3:0]         be_mask;
  logic [31:0]        wdata_rep;
  logic [31:0]        lane, load_ext;

  // Request decode
  always_comb begin
    is_ld   = (opcode == 7'b0000011);
    is_st   = (opcode == 7'b0100011);
    access  = mem_flag & (is_ld | is_st);
    illegal = is_ld ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                    : (funct3 >= 3'b011);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    off_eff  = addr[1:0];
`else
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   off_eff = {addr[1], 1'b0};
      2'b10:   off_eff = 2'b00;
      default: off_eff = addr[1:0];
    endcase
`endif
    case (funct3[1:0])
      2'b00:   be_mask = 4'b0001 << off_eff;
      2'b01:   be_mask = 4'b0011 << off_eff;
      default: be_mask = 4'b1111;
    endcase
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load lane select and extension from the latched width/offset
  always_comb begin
    lane = dmem.dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    f3_d      = f3_q;
    off_d     = off_q;
    err_d     = err_q;
    we_d      = we_q;
    baddr_d   = baddr_q;
    be_d      = be_q;
    bwdata_d  = bwdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          is_load_d = is_ld;
          f3_d      = funct3;
          off_d     = off_eff;
          if (illegal || misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d    = 1'b0;
            state_d  = REQ;
            cnt_d    = '0;
            we_d     = is_st;
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = be_mask;
            bwdata_d = is_st ? wdata_rep : '0;
          end
        end
      end
      REQ: begin
        // Ack is checked first so an ack in the last allowed cycle succeeds.
        if (dmem.dmem_ack) begin
          state_d = DONE;
          if (is_load_q) rdata_d = load_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= '0;
      be_q      <= '0;
      bwdata_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      err_q     <= err_d;
      we_q      <= we_d;
      baddr_q   <= baddr_d;
      be_q      <= be_d;
      bwdata_q  <= bwdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request derives from the state register so reset drops it immediately.
  assign stall           = ((state_q == IDLE) & access) | (state_q == REQ);
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = baddr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = bwdata_q;
  assign done            = (state_q == DONE);
  assign err             = (state_q == DONE) & err_q;
  assign rvalid          = (state_q == DONE) & ~err_q & is_load_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int unsigned TO = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_flag = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, rvalid, done, err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdata_model = '0;

  lsu_ctrl_if dmem_if ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_flag (mem_flag),
    .opcode   (opcode),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .done     (done),
    .err      (err),
    .dmem     (dmem_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: access rules computed from byte counts and arithmetic.
  function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output bit e, output int off,
                                output int nb, output logic [3:0] be, output logic [31:0] bw);
    int lo;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e  = ld ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 > 3'd2);
    lo = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    if (lo % nb != 0) e = 1'b1;
    off = lo;
`else
    off = lo - (lo % nb);
`endif
    be = 4'(((1 << nb) - 1) << off);
    bw = '0;
    if (!ld)
      for (int i = 0; i < 4; i++) bw[8*i +: 8] = wd[8*(i % nb) +: 8];
  endfunction

  function automatic logic [31:0] ld_result(input logic [2:0] f3, input int off, input int nb,
                                            input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] m;
    v = rd >> (8 * off);
    if (nb == 4) return v;
    m = (32'd1 << (8 * nb)) - 32'd1;
    v = v & m;
    if (!f3[2] && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  // One access from an IDLE cycle; ack raised in REQ cycle ack_at (0-based),
  // ack_at < 0 means never. Ends in the IDLE cycle after DONE.
  task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    bit e;
    int off, nb, req_n, stall_n, exp_req;
    logic [3:0] be;
    logic [31:0] bw;
    model(ld, f3, a, wd, e, off, nb, be, bw);
    mem_flag = 1'b1;
    opcode   = ld ? OP_LOAD : OP_STORE;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    #1;
    check("stall_accept", stall, 1'b1);
    stall_n = (stall === 1'b1) ? 1 : 0;
    tick();
    mem_flag = 1'b0;
    opcode   = 7'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    req_n    = 0;
    exp_req  = e ? 0 : ((ack_at >= 0 && ack_at < int'(TO)) ? ack_at + 1 : int'(TO));
    while (dmem_if.dmem_req === 1'b1 && req_n < int'(TO) + 3) begin
      check("req_we", dmem_if.dmem_we, !ld);
      check("req_addr", dmem_if.dmem_addr, {a[31:2], 2'b00});
      check("req_be", dmem_if.dmem_be, be);
      check("req_wdata", dmem_if.dmem_wdata, bw);
      if (stall === 1'b1) stall_n++;
      dmem_if.dmem_ack   = (req_n == ack_at);
      dmem_if.dmem_rdata = (req_n == ack_at) ? rd : $urandom;
      req_n++;
      tick();
    end
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = $urandom;
    check("req_cycles", req_n, exp_req);
    if (!e && ld && ack_at >= 0 && ack_at < int'(TO))
      rdata_model = ld_result(f3, off, nb, rd);
    check("done", done, 1'b1);
    check("err", err, (e || !(ack_at >= 0 && ack_at < int'(TO))) ? 1'b1 : 1'b0);
    check("rvalid", rvalid, (ld && !e && ack_at >= 0 && ack_at < int'(TO)) ? 1'b1 : 1'b0);
    check("rdata", rdata, rdata_model);
    check("stall_done", stall, 1'b0);
    check("req_done", dmem_if.dmem_req, 1'b0);
    check("stall_cycles", stall_n, 1 + exp_req);
    // A flagged load presented during DONE must not start an access.
    mem_flag = 1'b1;
    opcode   = OP_LOAD;
    funct3   = 3'b010;
    tick();
    mem_flag = 1'b0;
    #1;
    check("idle_done", done, 1'b0);
    check("idle_req", dmem_if.dmem_req, 1'b0);
    check("idle_rvalid", rvalid, 1'b0);
  endtask

  initial begin
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    tick();
    tick();
    check("rst_stall", stall, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req", dmem_if.dmem_req, 1'b0);
    check("rst_we", dmem_if.dmem_we, 1'b0);
    check("rst_addr", dmem_if.dmem_addr, 32'h0);
    check("rst_be", dmem_if.dmem_be, 4'h0);
    check("rst_wdata", dmem_if.dmem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Ack outside REQ is ignored.
    dmem_if.dmem_ack = 1'b1;
    tick();
    tick();
    check("stray_ack_req", dmem_if.dmem_req, 1'b0);
    check("stray_ack_done", done, 1'b0);
    dmem_if.dmem_ack = 1'b0;

    // Non-memory opcode with mem_flag is ignored.
    mem_flag = 1'b1;
    opcode   = 7'b0110011;
    #1;
    check("other_op_stall", stall, 1'b0);
    tick();
    check("other_op_req", dmem_if.dmem_req, 1'b0);
    check("other_op_done", done, 1'b0);
    mem_flag = 1'b0;

    // Directed cases
    access(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0);
    access(1'b1, 3'b000, 32'h0000_0203, 32'h0, 3, 32'h80FF_FFFF);
    check("lb_value", rdata, 32'hFFFF_FF80);
    access(1'b1, 3'b100, 32'h0000_0203, 32'h0, 3, 32'h80FF_FFFF);
    check("lbu_value", rdata, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 1, 32'h0);
    access(1'b1, 3'b010, 32'h0000_0080, 32'h0, -1, 32'h0);
    access(1'b0, 3'b000, 32'h0000_0081, 32'h1234_5678, -1, 32'h0);
    access(1'b1, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h1357_9BDF);
    access(1'b1, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h0);
    access(1'b1, 3'b110, 32'h0000_0040, 32'h0, 0, 32'h0);
    access(1'b1, 3'b111, 32'h0000_0040, 32'h0, 0, 32'h0);
    access(1'b0, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h0);
    access(1'b0, 3'b111, 32'h0000_0040, 32'h0, 0, 32'h0);
    access(1'b1, 3'b101, 32'h0000_0033, 32'h0, 2, 32'h8001_7FFF);

    // Randomized back-to-back accesses
    for (int n = 0; n < 60; n++)
      access(1'($urandom), 3'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom);

    // Reset during REQ abandons the access.
    mem_flag = 1'b1;
    opcode   = OP_LOAD;
    funct3   = 3'b010;
    addr     = 32'h0000_0040;
    tick();
    mem_flag = 1'b0;
    check("mid_req_before", dmem_if.dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", dmem_if.dmem_req, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_be", dmem_if.dmem_be, 4'h0);
    check("mid_rst_addr", dmem_if.dmem_addr, 32'h0);
    check("mid_rst_we", dmem_if.dmem_we, 1'b0);
    check("mid_rst_wdata", dmem_if.dmem_wdata, 32'h0);
    rdata_model = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_done", done, 1'b0);
    check("post_rst_req", dmem_if.dmem_req, 1'b0);
    access(1'b1, 3'b001, 32'h0000_0046, 32'h0, 0, 32'hC0DE_8123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
